gb_timer: RTL and testbench

Game Boy DIV/TIMA/TMA/TAC timer unit, replacing the free-running divide counters and timer-count increment currently built into the top level. It sits between the memory unit's I/O register port (FF04–FF07) and the interrupt-status register, and produces the one-cycle timer interrupt request that sets IF bit 2. Counting follows DMG falling-edge semantics, including delayed overflow reload and the spurious-increment side effects of DIV/TAC writes.

---
 rtl/gb_timer_pkg.sv | 38 +++
 rtl/gb_timer_if.sv | 11 +
 rtl/gb_timer_edge_sel.sv | 27 ++
 rtl/gb_timer.sv | 132 +++++++++++++
 tb/tb_gb_timer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_timer_pkg.sv
// Shared types and constants for the DMG DIV/TIMA/TMA/TAC timer.
package gb_timer_pkg;

  localparam int RELOAD_DELAY = 4;
  localparam int DLY_W = (RELOAD_DELAY > 2) ? $clog2(RELOAD_DELAY) : 1;

  typedef enum logic [1:0] {
    ADDR_DIV  = 2'b00,
    ADDR_TIMA = 2'b01,
    ADDR_TMA  = 2'b10,
    ADDR_TAC  = 2'b11
  } tmr_addr_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    WAIT   = 2'b01,
    RELOAD = 2'b10
  } tmr_state_e;

  localparam logic [3:0] TAC_TAP_00 = 4'd9;
  localparam logic [3:0] TAC_TAP_01 = 4'd3;
  localparam logic [3:0] TAC_TAP_10 = 4'd5;
  localparam logic [3:0] TAC_TAP_11 = 4'd7;

  localparam logic [7:0] TAC_READ_MASK = 8'hF8;

  function automatic logic [3:0] tac_tap(input logic [1:0] sel);
    logic [3:0] bit_idx;
    unique case (sel)
      2'b00:   bit_idx = TAC_TAP_00;
      2'b01:   bit_idx = TAC_TAP_01;
      2'b10:   bit_idx = TAC_TAP_10;
      default: bit_idx = TAC_TAP_11;
    endcase
    return bit_idx;
  endfunction

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side register port of the timer (FF04-FF07).
interface gb_timer_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gb_timer_edge_sel.sv
// Selects the TAC tap of the system counter and flags its falling edge,
// which is what clocks TIMA on the DMG.
module tmr_edge_sel
  import gb_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sys_cnt,
  input  logic [2:0]  tac,
  output logic        tick_fall
);

  logic tick_in;
  logic tick_prev;

  assign tick_in   = sys_cnt[tac_tap(tac[1:0])] & tac[2];
  assign tick_fall = tick_prev & ~tick_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_prev <= 1'b0;
    end else begin
      tick_prev <= tick_in;
    end
  end

endmodule

// File: rtl/gb_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC register file with the delayed-reload
// overflow FSM that raises a one-clock timer interrupt request.
module gb_timer
  import gb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  gb_timer_if.slave  bus,
  output logic       timer_irq,
  output logic [7:0] div_out
);

  logic [15:0]      sys_cnt;
  logic [7:0]       tima;
  logic [7:0]       tma;
  logic [2:0]       tac;
  tmr_state_e       state;
  tmr_state_e       state_next;
  logic [DLY_W-1:0] dly_cnt;
  logic [DLY_W-1:0] dly_next;
  logic [7:0]       tima_next;
  logic [7:0]       rd_val;
  logic             tick_fall;
  logic             wr;
  logic             rd;
  logic             div_wr;
  logic             tima_wr;
  logic             tma_wr;
  logic             tac_wr;

  assign wr      = bus.cs & bus.we;
  assign rd      = bus.cs & ~bus.we;
  assign div_wr  = wr && (tmr_addr_e'(bus.addr) == ADDR_DIV);
  assign tima_wr = wr && (tmr_addr_e'(bus.addr) == ADDR_TIMA);
  assign tma_wr  = wr && (tmr_addr_e'(bus.addr) == ADDR_TMA);
  assign tac_wr  = wr && (tmr_addr_e'(bus.addr) == ADDR_TAC);

  assign div_out   = sys_cnt[15:8];
  assign timer_irq = (state == RELOAD);

  tmr_edge_sel u_edge_sel (
    .clk       (clk),
    .rst       (rst),
    .sys_cnt   (sys_cnt),
    .tac       (tac),
    .tick_fall (tick_fall)
  );

  // Overflow handling: TIMA sits at 00 while the reload is pending, and the
  // reload cycle takes TMA as it is being written on that same clock.
  always_comb begin
    state_next = state;
    dly_next   = dly_cnt;
    tima_next  = tima;
    unique case (state)
      RUN: begin
        if (tima_wr) begin
          tima_next = bus.wdata;
        end else if (tick_fall) begin
          if (tima == 8'hFF) begin
            tima_next  = 8'h00;
            state_next = WAIT;
            dly_next   = DLY_W'(RELOAD_DELAY - 1);
          end else begin
            tima_next = tima + 8'h01;
          end
        end
      end
      WAIT: begin
        if (tima_wr) begin
          tima_next  = bus.wdata;
          state_next = RUN;
        end else begin
          dly_next = dly_cnt - DLY_W'(1);
          if (dly_cnt <= DLY_W'(1)) begin
            state_next = RELOAD;
          end
        end
      end
      RELOAD: begin
        tima_next  = tma_wr ? bus.wdata : tma;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      dly_cnt <= '0;
      tima    <= 8'h00;
    end else begin
      state   <= state_next;
      dly_cnt <= dly_next;
      tima    <= tima_next;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    unique case (tmr_addr_e'(bus.addr))
      ADDR_DIV:  rd_val = sys_cnt[15:8];
      ADDR_TIMA: rd_val = tima;
      ADDR_TMA:  rd_val = tma;
      default:   rd_val = TAC_READ_MASK | {5'b00000, tac};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cnt   <= 16'h0000;
      tma       <= 8'h00;
      tac       <= 3'b000;
      bus.rdata <= 8'h00;
    end else begin
      sys_cnt <= div_wr ? 16'h0000 : sys_cnt + 16'h0001;
      if (tma_wr) begin
        tma <= bus.wdata;
      end
      if (tac_wr) begin
        tac <= bus.wdata[2:0];
      end
      if (rd) begin
        bus.rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer; register reads are scored against a
// queue of expected values pushed when each read is issued.
module tb_gb_timer;
  import gb_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timer_irq;
  logic [7:0] div_out;

  gb_timer_if bus ();

  gb_timer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timer_irq (timer_irq),
    .div_out   (div_out)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         irq_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always @(posedge clk) begin
    if (timer_irq === 1'b1) irq_seen++;
  end

  // Bus tasks are entered on a falling edge; the access is sampled on the
  // next rising edge and the task returns on the falling edge after it.
  task automatic bus_write(input tmr_addr_e a, input logic [7:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input tmr_addr_e a);
    bus.addr = a; bus.we = 1'b0; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // DIV cleared on edge 0, TAC=05 on edge 1, so sys_cnt equals the edge index.
  task automatic setup_run(input logic [7:0] tma_v, input logic [7:0] tima_v);
    bus_write(ADDR_DIV, 8'h5A);
    bus_write(ADDR_TAC, 8'h05);
    bus_write(ADDR_TMA, tma_v);
    bus_write(ADDR_TIMA, tima_v);
  endtask

  task automatic test_reset();
    tmr_addr_e addrs[4] = '{ADDR_TIMA, ADDR_TMA, ADDR_TAC, ADDR_DIV};
    do_reset();
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 00", bus.rdata); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", timer_irq); end
    n_checks++;
    if (div_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_div_out: got %h want 00", div_out); end
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hF8); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL reset_read%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
  endtask

  task automatic test_count();
    int s0;
    do_reset();
    s0 = irq_seen;
    setup_run(8'h00, 8'hFE);
    idle(13);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    for (int i = 0; i < 2; i++) begin
      bus_read(ADDR_TIMA);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL count_a%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
    idle(14);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      bus_read(ADDR_TIMA);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL count_b%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_checks++;
      if (timer_irq !== (i == 1)) begin n_fail++; $display("[TB] FAIL count_irq%0d: got %b want %b", i, timer_irq, (i == 1)); end
    end
    exp_q.push_back(8'h00);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL count_reload: got %h want %h", bus.rdata, exp_v); end
    n_checks++;
    if (irq_seen - s0 !== 1) begin n_fail++; $display("[TB] FAIL count_irq_total: got %0d want 1", irq_seen - s0); end
  endtask

  task automatic test_reload_delay();
    int hits = 0;
    int hit_idx = -1;
    logic [7:0] seq[6] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0};
    do_reset();
    setup_run(8'hA0, 8'hFF);
    idle(13);
    for (int i = 0; i < 6; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 6; i++) begin
      bus_read(ADDR_TIMA);
      if (timer_irq === 1'b1) begin hits++; hit_idx = i; end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL reload_seq%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
    n_checks++;
    if (hits !== 1) begin n_fail++; $display("[TB] FAIL reload_irq_width: got %0d want 1", hits); end
    n_checks++;
    if (hit_idx !== 3) begin n_fail++; $display("[TB] FAIL reload_irq_pos: got %0d want 3", hit_idx); end
  endtask

  task automatic test_wait_write();
    int s0;
    do_reset();
    s0 = irq_seen;
    setup_run(8'hA0, 8'hFF);
    idle(15);
    bus_write(ADDR_TIMA, 8'h33);
    idle(5);
    exp_q.push_back(8'h33);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL wait_write: got %h want %h", bus.rdata, exp_v); end
    idle(8);
    exp_q.push_back(8'h34);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL wait_write_inc: got %h want %h", bus.rdata, exp_v); end
    n_checks++;
    if (irq_seen !== s0) begin n_fail++; $display("[TB] FAIL wait_write_irq: got %0d pulses want 0", irq_seen - s0); end
  endtask

  task automatic test_reload_writes();
    int s0;
    do_reset();
    s0 = irq_seen;
    setup_run(8'hA0, 8'hFF);
    idle(17);
    bus_write(ADDR_TMA, 8'h77);
    exp_q.push_back(8'h77); exp_q.push_back(8'h77);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL reload_tma_tima: got %h want %h", bus.rdata, exp_v); end
    bus_read(ADDR_TMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL reload_tma_reg: got %h want %h", bus.rdata, exp_v); end
    n_checks++;
    if (irq_seen - s0 !== 1) begin n_fail++; $display("[TB] FAIL reload_tma_irq: got %0d want 1", irq_seen - s0); end
    do_reset();
    setup_run(8'hA0, 8'hFF);
    idle(17);
    bus_write(ADDR_TIMA, 8'h55);
    exp_q.push_back(8'hA0);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL reload_tima_ignored: got %h want %h", bus.rdata, exp_v); end
  endtask

  task automatic test_div_write();
    logic [7:0] seq[2] = '{8'h11, 8'h12};
    do_reset();
    setup_run(8'h00, 8'h10);
    idle(6);
    bus_write(ADDR_DIV, 8'hC3);
    exp_q.push_back(8'h00);
    bus_read(ADDR_DIV);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL divwr_div: got %h want %h", bus.rdata, exp_v); end
    exp_q.push_back(8'h11);
    bus_read(ADDR_TIMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL divwr_spurious: got %h want %h", bus.rdata, exp_v); end
    idle(14);
    for (int i = 0; i < 2; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 2; i++) begin
      bus_read(ADDR_TIMA);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL divwr_phase%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
  endtask

  task automatic test_tap_select();
    int tap_bit[4] = '{9, 3, 5, 7};
    int fall;
    for (int s = 0; s < 4; s++) begin
      do_reset();
      bus_write(ADDR_DIV, 8'h00);
      bus_write(ADDR_TAC, {5'b00000, 1'b1, 2'(s)});
      bus_write(ADDR_TIMA, 8'h00);
      fall = 1 << (tap_bit[s] + 1);
      idle(fall - 2);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      for (int i = 0; i < 2; i++) begin
        bus_read(ADDR_TIMA);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL tap%0d_read%0d: got %h want %h", s, i, bus.rdata, exp_v); end
      end
    end
  endtask

  task automatic test_div_count();
    do_reset();
    bus_write(ADDR_DIV, 8'h00);
    idle(299);
    exp_q.push_back(8'h01);
    bus_read(ADDR_DIV);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL div_read: got %h want %h", bus.rdata, exp_v); end
    idle(300);
    n_checks++;
    if (div_out !== 8'h02) begin n_fail++; $display("[TB] FAIL div_out_live: got %h want 02", div_out); end
  endtask

  task automatic test_async_reset();
    int s0;
    tmr_addr_e addrs[4] = '{ADDR_TAC, ADDR_TIMA, ADDR_TMA, ADDR_DIV};
    logic [7:0] seq[4] = '{8'hF8, 8'h00, 8'h00, 8'h00};
    do_reset();
    setup_run(8'hA0, 8'hFF);
    exp_q.push_back(8'hA0);
    bus_read(ADDR_TMA);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL arst_pre_tma: got %h want %h", bus.rdata, exp_v); end
    idle(14);
    s0 = irq_seen;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL arst_rdata: got %h want 00", bus.rdata); end
    n_checks++;
    if (timer_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_irq_now: got %b want 0", timer_irq); end
    idle(6);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i]);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.rdata !== exp_v) begin n_fail++; $display("[TB] FAIL arst_read%0d: got %h want %h", i, bus.rdata, exp_v); end
    end
    idle(8);
    n_checks++;
    if (irq_seen !== s0) begin n_fail++; $display("[TB] FAIL arst_no_irq: got %0d pulses want 0", irq_seen - s0); end
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'b00; bus.wdata = 8'h00;
    test_reset();
    test_count();
    test_reload_delay();
    test_wait_write();
    test_reload_writes();
    test_div_write();
    test_tap_select();
    test_div_count();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
